// File: rtl/mac_accumulator.sv
// Signed multiply-accumulate over K operand beats with a saturating,
// single-entry output register and ready/valid handshakes on both sides.
module mac_accumulator #(
    parameter int N = 8,
    parameter int K = 9
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   act,
    input  logic [N-1:0]   weight,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           sat
);

    localparam int CW = $clog2(K);
    localparam int AW = 2 * N + CW;

    localparam logic signed [AW-1:0] ACC_MAX = {{(CW + 1){1'b0}}, {(2 * N - 1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {{(CW + 1){1'b1}}, {(2 * N - 1){1'b0}}};
    localparam logic [2*N-1:0]       OUT_MAX = {1'b0, {(2 * N - 1){1'b1}}};
    localparam logic [2*N-1:0]       OUT_MIN = {1'b1, {(2 * N - 1){1'b0}}};

    typedef enum logic {
        EMPTY,
        FULL
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [2*N-1:0]         product_q, product_d;
    logic                   sat_q, sat_d;

    logic signed [2*N-1:0]  mul;
    logic signed [AW-1:0]   sum;
    logic                   last_beat;
    logic                   accept;
    logic                   clip_hi;
    logic                   clip_lo;

    always_comb begin
        mul       = $signed(act) * $signed(weight);
        sum       = acc_q + $signed({{CW{mul[2*N-1]}}, mul});
        clip_hi   = (sum > ACC_MAX);
        clip_lo   = (sum < ACC_MIN);
        last_beat = (count_q == CW'(K - 1));
        // Only the completing beat stalls, and only while the held result is not being consumed.
        in_ready  = !((state_q == FULL) && !out_ready && last_beat);
        accept    = in_valid && in_ready && !flush;

        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        product_d = product_q;
        sat_d     = sat_q;

        if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end

        if (flush) begin
            acc_d   = '0;
            count_d = '0;
        end else if (accept) begin
            if (last_beat) begin
                acc_d     = '0;
                count_d   = '0;
                state_d   = FULL;
                sat_d     = clip_hi || clip_lo;
                if (clip_hi) begin
                    product_d = OUT_MAX;
                end else if (clip_lo) begin
                    product_d = OUT_MIN;
                end else begin
                    product_d = sum[2*N-1:0];
                end
            end else begin
                acc_d   = sum;
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            count_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            sat_q     <= sat_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign product   = product_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: directed scenarios plus random traffic, all
// checked every cycle against an arithmetic window/sum model.
module tb_mac_accumulator;

    localparam int N = 8;
    localparam int K = 9;
    localparam longint PMAX = (64'sd1 <<< (2 * N - 1)) - 1;
    localparam longint PMIN = -(64'sd1 <<< (2 * N - 1));

    logic           clock;
    logic           reset_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   act;
    logic [N-1:0]   weight;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;
    logic           sat;

    int vectors = 0;
    int errors  = 0;

    // Reference model: result register plus the running window sum.
    bit     m_full;
    bit     m_sat;
    longint m_prod;
    longint m_acc;
    int     m_count;

    mac_accumulator #(.N(N), .K(K)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .act      (act),
        .weight   (weight),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
        .sat      (sat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        vectors++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_ready(input bit ordy);
        return !(m_full && !ordy && (m_count == K - 1));
    endfunction

    function automatic void m_reset();
        m_full  = 1'b0;
        m_sat   = 1'b0;
        m_prod  = 0;
        m_acc   = 0;
        m_count = 0;
    endfunction

    function automatic void m_edge(input bit v, input int a, input int w, input bit ordy, input bit fl);
        bit done;
        bit took;
        longint s;
        done = 1'b0;
        took = v && m_ready(ordy);
        if (fl) begin
            m_acc   = 0;
            m_count = 0;
        end else if (took) begin
            m_acc   = m_acc + longint'(a) * longint'(w);
            m_count = m_count + 1;
            if (m_count == K) begin
                s = m_acc;
                if (s > PMAX) begin
                    m_prod = PMAX; m_sat = 1'b1;
                end else if (s < PMIN) begin
                    m_prod = PMIN; m_sat = 1'b1;
                end else begin
                    m_prod = s; m_sat = 1'b0;
                end
                m_acc   = 0;
                m_count = 0;
                done    = 1'b1;
            end
        end
        if (done) m_full = 1'b1;
        else if (m_full && ordy) m_full = 1'b0;
    endfunction

    task automatic compare_outputs(input bit ordy);
        check_eq("in_ready", longint'(in_ready), longint'(m_ready(ordy)));
        check_eq("out_valid", longint'(out_valid), longint'(m_full));
        check_eq("product", longint'($signed(product)), m_prod);
        check_eq("sat", longint'(sat), longint'(m_sat));
    endtask

    // Drive one cycle from a negedge, check before the posedge, update model after it.
    task automatic step(input bit v, input int a, input int w, input bit ordy, input bit fl);
        in_valid  = v;
        act       = a[N-1:0];
        weight    = w[N-1:0];
        out_ready = ordy;
        flush     = fl;
        #1;
        compare_outputs(ordy);
        @(posedge clock);
        m_edge(v, a, w, ordy, fl);
        @(negedge clock);
    endtask

    task automatic beats(input int n, input int a, input int w, input bit ordy);
        for (int i = 0; i < n; i++) step(1'b1, a, w, ordy, 1'b0);
    endtask

    task automatic async_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        m_reset();
        check_eq("rst_out_valid", longint'(out_valid), 0);
        check_eq("rst_product", longint'($signed(product)), 0);
        check_eq("rst_sat", longint'(sat), 0);
        check_eq("rst_in_ready", longint'(in_ready), 1);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int a;
        int w;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        act       = '0;
        weight    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        m_reset();
        #1;
        check_eq("init_out_valid", longint'(out_valid), 0);
        check_eq("init_in_ready", longint'(in_ready), 1);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Basic window of ones.
        beats(K, 1, 1, 1'b1);
        check_eq("basic_valid", longint'(out_valid), 1);
        check_eq("basic_prod", longint'($signed(product)), 9);
        check_eq("basic_sat", longint'(sat), 0);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        check_eq("basic_single_pulse", longint'(out_valid), 0);

        // Saturation both ways.
        beats(K, -128, -128, 1'b1);
        check_eq("sat_pos_prod", longint'($signed(product)), 32767);
        check_eq("sat_pos_flag", longint'(sat), 1);
        beats(K, 127, -128, 1'b1);
        check_eq("sat_neg_prod", longint'($signed(product)), -32768);
        check_eq("sat_neg_flag", longint'(sat), 1);
        step(1'b0, 0, 0, 1'b1, 1'b0);

        // Backpressure: hold result 9, only the completing beat of the next window stalls.
        beats(K, 1, 1, 1'b0);
        beats(K - 1, 2, 3, 1'b0);
        step(1'b1, 2, 3, 1'b0, 1'b0);
        step(1'b1, 2, 3, 1'b0, 1'b0);
        #1;
        check_eq("bp_in_ready_low", longint'(in_ready), 0);
        check_eq("bp_hold_prod", longint'($signed(product)), 9);
        @(negedge clock);
        step(1'b1, 2, 3, 1'b1, 1'b0);
        check_eq("bp_next_prod", longint'($signed(product)), 54);
        check_eq("bp_next_valid", longint'(out_valid), 1);
        step(1'b0, 0, 0, 1'b1, 1'b0);

        // Flush discards the partial sum and the beat presented with it.
        beats(4, 5, 5, 1'b1);
        step(1'b1, 5, 5, 1'b1, 1'b1);
        beats(K, 1, 1, 1'b1);
        check_eq("flush_prod", longint'($signed(product)), 9);
        step(1'b0, 0, 0, 1'b1, 1'b0);

        // Reset mid-window, then reset while holding a result.
        beats(5, 1, 1, 1'b1);
        async_reset();
        beats(K, 1, -1, 1'b1);
        check_eq("rst_mid_prod", longint'($signed(product)), -9);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        beats(K, 1, 1, 1'b0);
        async_reset();
        beats(K, 1, -1, 1'b1);
        check_eq("rst_full_prod", longint'($signed(product)), -9);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = ($urandom_range(0, 1) == 1) ? 127 : -128;
                w = ($urandom_range(0, 1) == 1) ? 127 : -128;
            end else begin
                a = int'($urandom_range(0, 255)) - 128;
                w = int'($urandom_range(0, 255)) - 128;
            end
            step($urandom_range(0, 9) < 7, a, w, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 99) < 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter N, default 8: signed width of each activation and weight operand.
REQ-002 Parameter K, default 9: number of products summed into one result (one 3x3 kernel window). Legal range 2..256.
REQ-003 clock  input  1  The single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  Asynchronous, active-low reset; assertion takes effect immediately, release is synchronous to clock.
REQ-005 in_valid  input  1  An operand pair is present on act/weight.
REQ-006 in_ready  output  1  The block accepts the operand pair this cycle.
REQ-007 act  input  N  Signed activation operand.
REQ-008 weight  input  N  Signed weight operand.
REQ-009 flush  input  1  Synchronous discard of the partial sum in progress.
REQ-010 out_valid  output  1  product/sat hold a completed result.
REQ-011 out_ready  input  1  The downstream stage (ReLU stage) consumes the result this cycle.
REQ-012 product  output  2N  Signed saturated dot-product result; feeds the activation stage directly.
REQ-013 sat  output  1  The result on product was clipped.

Function
REQ-014 An operand beat is accepted when in_valid && in_ready at a rising edge.
REQ-015 The internal accumulator SHALL be signed, 2N+clog2(K) bits wide, and SHALL never wrap.
REQ-016 A beat counter (0..K-1) SHALL advance on each accepted beat. It SHALL return to 0 after the K-th beat.
REQ-017 On each accepted beat that is not the K-th, acc <= acc + act*weight, computed as a full-precision signed product.
REQ-018 On the K-th accepted beat, the block SHALL form sum = acc + act*weight and load it into the output register in the same edge:
- product <= sum clipped to [-2^(2N-1), 2^(2N-1)-1]
- sat <= 1 iff clipping occurred
- out_valid <= 1
- acc <= 0
REQ-019 Latency: the result is visible the cycle after the K-th beat is accepted.
REQ-020 Output state machine: EMPTY (out_valid=0) and FULL (out_valid=1).
- EMPTY -> FULL on the K-th beat.
- FULL -> EMPTY on out_ready, unless a K-th beat is accepted in the same cycle; in that case the block stays FULL and loads the new result.
REQ-021 product and sat SHALL hold stable while FULL and out_ready=0.
REQ-022 in_ready = !(out_valid && !out_ready && count==K-1). Beats of the next window accumulate while a result is held; only the completing beat stalls. The combinational path out_ready -> in_ready is permitted.
REQ-023 flush=1 at an edge SHALL clear acc and count to 0. Any beat accepted in that same cycle SHALL be discarded, so flush wins. flush SHALL NOT alter out_valid, product or sat.
REQ-024 in_ready SHALL NOT depend on in_valid.

Reset
REQ-025 While reset_n=0:
- acc=0, count=0
- out_valid=0, product=0, sat=0
- state=EMPTY
- in_ready=1
REQ-026 Reset asserted mid-window or while FULL SHALL discard all partial and held data. The first beat after release is beat 1 of a new window.

Verification (N=8, K=9)
REQ-027 Basic: 9 beats act=1, weight=1, out_ready=1 -> exactly one out_valid pulse, 1 cycle after beat 9; product=9, sat=0.
REQ-028 Saturation:
- 9 beats of -128*-128 (sum 147456) -> product=32767, sat=1.
- 9 beats of 127*-128 (sum -146304) -> product=-32768, sat=1.
REQ-029 Backpressure: out_ready=0 after result 1 (value 9). Stream 9 beats act=2, weight=3.
- 8 beats are accepted; in_ready drops before beat 9.
- product stays 9.
- Raising out_ready accepts beat 9 that cycle; next product=54.
REQ-030 Flush: 4 beats of 5*5, then flush=1 together with a valid beat, then 9 beats of 1*1 -> product=9. The flushed-cycle beat is not counted.
REQ-031 Reset: drive reset_n low after 5 beats, or while FULL with out_ready=0 -> all outputs 0 immediately. Then 9 beats of 1*-1 -> product=-9.
REQ-032 Random: constrained-random in_valid/out_ready/flush against a reference model. No result is lost or duplicated, and product/sat are stable while stalled.
